// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
//   Shared definitions for the MiniMIPS32 data-memory responder:
//   default MMIO window base, MMIO word offsets, UART transmitter state
//   encoding and a byte-enable merge helper.
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

    // daddr[31:16] value that selects the MMIO window
    localparam logic [15:0] MMIO_BASE_DEFAULT = 16'hBFD0;

    // MMIO word offsets (daddr[7:2])
    localparam logic [5:0] LED_OFF   = 6'h00;
    localparam logic [5:0] TIMER_OFF = 6'h01;
    localparam logic [5:0] UTX_OFF   = 6'h02;
    localparam logic [5:0] USTAT_OFF = 6'h03;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    // Replace the bytes of old_word selected by be with the matching bytes of wdata.
    function automatic logic [31:0] apply_be(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_responder_uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   8N1 UART transmitter. A start pulse while idle latches data and sends
//   start bit, 8 data bits LSB first and a stop bit, each CLK_DIV cycles long.
//   Start pulses while a frame is in flight are dropped, except in the very
//   last cycle of the stop bit, where the next frame follows seamlessly.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   start in   request to send data
//   data  in   byte to send (latched on an accepted start)
//   busy  out  high whenever the FSM is not IDLE
//   txd   out  registered serial output, idles high
// -----------------------------------------------------------------------------
module uart_tx
    import dmem_responder_pkg::*;
#(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       txd
);

    localparam int unsigned    CW       = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(CLK_DIV - 1);

    uart_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [2:0]    idx_q,   idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          txd_q,   txd_d;
    logic          bit_done;
    logic          accept;

    always_comb begin
        bit_done = (cnt_q == '0);
        // The final stop-bit cycle counts as idle for a new request.
        accept   = start && ((state_q == UART_IDLE) ||
                             (state_q == UART_STOP && bit_done));

        state_d = state_q;
        cnt_d   = cnt_q - CW'(1);
        idx_d   = idx_q;
        shreg_d = shreg_q;
        txd_d   = txd_q;

        case (state_q)
            UART_IDLE: begin
                cnt_d = cnt_q;
                txd_d = 1'b1;
            end
            UART_START: begin
                if (bit_done) begin
                    state_d = UART_DATA;
                    cnt_d   = CNT_LOAD;
                    idx_d   = 3'd0;
                    txd_d   = shreg_q[0];
                end
            end
            UART_DATA: begin
                if (bit_done) begin
                    cnt_d   = CNT_LOAD;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = UART_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        txd_d = shreg_q[1];
                    end
                end
            end
            UART_STOP: begin
                if (bit_done) begin
                    state_d = UART_IDLE;
                    cnt_d   = cnt_q;
                    txd_d   = 1'b1;
                end
            end
            default: begin
                state_d = UART_IDLE;
                txd_d   = 1'b1;
            end
        endcase

        if (accept) begin
            state_d = UART_START;
            cnt_d   = CNT_LOAD;
            idx_d   = 3'd0;
            shreg_d = data;
            txd_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UART_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            txd_q   <= txd_d;
        end
    end

    always_comb begin
        busy = (state_q != UART_IDLE);
        txd  = txd_q;
    end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Responder end of the MiniMIPS32 data-memory port. Decodes the address into
//   a word-addressed, byte-writable data RAM or an MMIO window (LED register,
//   free-running timer, UART transmitter and its status). Read data is
//   registered into dm, one cycle of latency.
// Ports:
//   cpu_clk_50M in   system clock
//   cpu_rst     in   synchronous active-high reset (RAM contents kept)
//   daddr[31:0] in   byte address, daddr[1:0] ignored
//   dce         in   access enable
//   we[3:0]     in   byte write enables, all zero with dce=1 is a read
//   din[31:0]   in   write data
//   dm[31:0]    out  registered read data, held until the next read
//   led[15:0]   out  LED register
//   uart_txd    out  UART serial output, idles high
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned RAM_AW    = 12,
    parameter int unsigned CLK_DIV   = 434,
    parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic [31:0] daddr,
    input  logic        dce,
    input  logic [3:0]  we,
    input  logic [31:0] din,
    output logic [31:0] dm,
    output logic [15:0] led,
    output logic        uart_txd
);

    logic [31:0] mem [2**RAM_AW];

    logic              is_mmio;
    logic [5:0]        mmio_off;
    logic [RAM_AW-1:0] ram_idx;
    logic              acc_rd;
    logic              acc_wr;
    logic              unused_addr;

    logic [31:0] dm_q,    dm_d;
    logic [15:0] led_q,   led_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] rd_data;
    logic        utx_start;
    logic        utx_busy;

    always_comb begin
        is_mmio     = (daddr[31:16] == MMIO_BASE);
        mmio_off    = daddr[7:2];
        ram_idx     = daddr[RAM_AW+1:2];
        acc_rd      = dce && (we == 4'b0000);
        acc_wr      = dce && (we != 4'b0000);
        unused_addr = ^{daddr[15:8], daddr[1:0]};
    end

    // MMIO register updates; a timer write overrides that cycle's increment.
    always_comb begin
        led_d     = led_q;
        timer_d   = timer_q + 32'd1;
        utx_start = 1'b0;
        if (acc_wr && is_mmio) begin
            case (mmio_off)
                LED_OFF: begin
                    if (we[0]) led_d[7:0]  = din[7:0];
                    if (we[1]) led_d[15:8] = din[15:8];
                end
                TIMER_OFF: timer_d   = apply_be(timer_q, din, we);
                UTX_OFF:   utx_start = we[0];
                default:   ;
            endcase
        end
    end

    // Timer reads return the count as it stands after the sampling edge,
    // so dm and the timer register agree at the moment dm updates.
    always_comb begin
        rd_data = '0;
        if (is_mmio) begin
            case (mmio_off)
                LED_OFF:   rd_data = {16'b0, led_q};
                TIMER_OFF: rd_data = timer_d;
                USTAT_OFF: rd_data = {31'b0, utx_busy};
                default:   rd_data = '0;
            endcase
        end else begin
            rd_data = mem[ram_idx];
        end
        dm_d = acc_rd ? rd_data : dm_q;
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            dm_q    <= '0;
            led_q   <= '0;
            timer_q <= '0;
        end else begin
            dm_q    <= dm_d;
            led_q   <= led_d;
            timer_q <= timer_d;
        end
    end

    // Data RAM: no reset, contents survive cpu_rst.
    always_ff @(posedge cpu_clk_50M) begin
        if (acc_wr && !is_mmio) begin
            mem[ram_idx] <= apply_be(mem[ram_idx], din, we);
        end
    end

    uart_tx #(
        .CLK_DIV(CLK_DIV)
    ) u_uart_tx (
        .clk   (cpu_clk_50M),
        .rst   (cpu_rst),
        .start (utx_start),
        .data  (din[7:0]),
        .busy  (utx_busy),
        .txd   (uart_txd)
    );

    always_comb begin
        dm  = dm_q;
        led = led_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Directed self-checking bench for dmem_responder with CLK_DIV=4.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam logic [31:0] A_LED   = 32'hBFD0_0000;
    localparam logic [31:0] A_TIMER = 32'hBFD0_0004;
    localparam logic [31:0] A_UTX   = 32'hBFD0_0008;
    localparam logic [31:0] A_USTAT = 32'hBFD0_000C;

    logic        clk;
    logic        rst;
    logic [31:0] daddr;
    logic        dce;
    logic [3:0]  we;
    logic [31:0] din;
    logic [31:0] dm;
    logic [15:0] led;
    logic        uart_txd;

    int total;
    int bad;

    dmem_responder #(
        .RAM_AW    (12),
        .CLK_DIV   (4),
        .MMIO_BASE (16'hBFD0)
    ) dut (
        .cpu_clk_50M (clk),
        .cpu_rst     (rst),
        .daddr       (daddr),
        .dce         (dce),
        .we          (we),
        .din         (din),
        .dm          (dm),
        .led         (led),
        .uart_txd    (uart_txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dce   = 1'b0;
        we    = 4'b0000;
        din   = '0;
        daddr = '0;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        daddr = a;
        we    = w;
        din   = d;
        dce   = 1'b1;
        tick();
        idle();
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] q);
        daddr = a;
        we    = 4'b0000;
        dce   = 1'b1;
        tick();
        idle();
        tick();
        q = dm;
    endtask

    task automatic test_reset();
        logic [31:0] q;
        rst = 1'b1;
        idle();
        repeat (3) tick();
        total++; if (dm !== 32'h0) begin bad++; $display("FAIL reset_dm got=%h exp=%h", dm, 32'h0); end
        total++; if (led !== 16'h0) begin bad++; $display("FAIL reset_led got=%h exp=%h", led, 16'h0); end
        total++; if (uart_txd !== 1'b1) begin bad++; $display("FAIL reset_txd got=%b exp=1", uart_txd); end
        rst = 1'b0;
        bus_rd(A_USTAT, q);
        total++; if (q !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=%h", q, 32'h0); end
    endtask

    task automatic test_ram_bytes();
        logic [31:0] q;
        bus_wr(32'h0000_0010, 4'hF, 32'h1122_3344);
        bus_wr(32'h0000_0010, 4'b0100, 32'hAABB_CCDD);
        bus_rd(32'h0000_0010, q);
        total++; if (q !== 32'h11BB_3344) begin bad++; $display("FAIL ram_byte got=%h exp=%h", q, 32'h11BB_3344); end
        // bit 14 lies above the 12-bit word index, so this aliases word 0x10
        bus_rd(32'h0000_4010, q);
        total++; if (q !== 32'h11BB_3344) begin bad++; $display("FAIL ram_alias got=%h exp=%h", q, 32'h11BB_3344); end
        bus_wr(32'h0000_0014, 4'hF, 32'hFFFF_FFFF);
        bus_wr(32'h0000_0014, 4'b1001, 32'h8765_4321);
        bus_rd(32'h0000_0014, q);
        total++; if (q !== 32'h87FF_FF21) begin bad++; $display("FAIL ram_be1001 got=%h exp=%h", q, 32'h87FF_FF21); end
    endtask

    task automatic test_back_to_back();
        daddr = 32'h0000_0020;
        we    = 4'hF;
        din   = 32'hCAFE_F00D;
        dce   = 1'b1;
        tick();
        we    = 4'b0000;
        din   = '0;
        tick();
        idle();
        tick();
        total++; if (dm !== 32'hCAFE_F00D) begin bad++; $display("FAIL b2b_read got=%h exp=%h", dm, 32'hCAFE_F00D); end
        bus_wr(32'h0000_0024, 4'hF, 32'h1234_5678);
        repeat (3) tick();
        total++; if (dm !== 32'hCAFE_F00D) begin bad++; $display("FAIL dm_hold got=%h exp=%h", dm, 32'hCAFE_F00D); end
    endtask

    task automatic test_led();
        logic [31:0] q;
        bus_wr(A_LED, 4'hF, 32'hDEAD_BEEF);
        total++; if (led !== 16'hBEEF) begin bad++; $display("FAIL led_write got=%h exp=%h", led, 16'hBEEF); end
        bus_rd(A_LED, q);
        total++; if (q !== 32'h0000_BEEF) begin bad++; $display("FAIL led_read got=%h exp=%h", q, 32'h0000_BEEF); end
        bus_wr(A_LED, 4'b1100, 32'hFFFF_FFFF);
        total++; if (led !== 16'hBEEF) begin bad++; $display("FAIL led_upper_ignored got=%h exp=%h", led, 16'hBEEF); end
        bus_wr(A_LED, 4'b0010, 32'h0000_1200);
        total++; if (led !== 16'h12EF) begin bad++; $display("FAIL led_byte1 got=%h exp=%h", led, 16'h12EF); end
        bus_rd(32'hBFD0_0010, q);
        total++; if (q !== 32'h0) begin bad++; $display("FAIL mmio_unmapped got=%h exp=%h", q, 32'h0); end
        bus_rd(A_UTX, q);
        total++; if (q !== 32'h0) begin bad++; $display("FAIL utx_read got=%h exp=%h", q, 32'h0); end
    endtask

    task automatic test_timer();
        logic [31:0] v1;
        logic [31:0] v2;
        bus_rd(A_TIMER, v1);
        repeat (8) tick();
        bus_rd(A_TIMER, v2);
        total++; if (v2 - v1 !== 32'd10) begin bad++; $display("FAIL timer_delta got=%0d exp=%0d", v2 - v1, 10); end
        bus_wr(A_TIMER, 4'hF, 32'hFFFF_FFFE);
        bus_rd(A_TIMER, v1);
        total++; if (v1 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL timer_plus1 got=%h exp=%h", v1, 32'hFFFF_FFFF); end
        bus_wr(A_TIMER, 4'hF, 32'hFFFF_FFFE);
        tick();
        bus_rd(A_TIMER, v1);
        total++; if (v1 !== 32'h0) begin bad++; $display("FAIL timer_wrap got=%h exp=%h", v1, 32'h0); end
        // byte write lands on 0x100 without the increment, then counting resumes
        bus_wr(A_TIMER, 4'hF, 32'h0000_0100);
        bus_wr(A_TIMER, 4'b0001, 32'h0000_0055);
        bus_rd(A_TIMER, v1);
        total++; if (v1 !== 32'h0000_0156) begin bad++; $display("FAIL timer_byte got=%h exp=%h", v1, 32'h0000_0156); end
    endtask

    task automatic test_uart_frame();
        logic [9:0]  frame;
        logic [31:0] q;
        frame = {1'b1, 8'hA5, 1'b0};
        bus_wr(A_UTX, 4'b0001, 32'h0000_00A5);
        for (int i = 0; i < 40; i++) begin
            total++;
            if (uart_txd !== frame[i/4]) begin
                bad++;
                $display("FAIL uart_bit cycle=%0d got=%b exp=%b", i, uart_txd, frame[i/4]);
            end
            if (i == 0 || i == 36) begin
                daddr = A_USTAT; we = 4'b0000; dce = 1'b1;
            end
            if (i == 1 || i == 37) idle();
            if (i == 2 || i == 38) begin
                total++; if (dm !== 32'h1) begin bad++; $display("FAIL uart_busy cycle=%0d got=%h exp=%h", i, dm, 32'h1); end
            end
            tick();
        end
        total++; if (uart_txd !== 1'b1) begin bad++; $display("FAIL uart_idle_line got=%b exp=1", uart_txd); end
        bus_rd(A_USTAT, q);
        total++; if (q !== 32'h0) begin bad++; $display("FAIL uart_done_status got=%h exp=%h", q, 32'h0); end
    endtask

    task automatic test_uart_busy_drop();
        logic [9:0] frame;
        logic       high_ok;
        frame = {1'b1, 8'hA5, 1'b0};
        bus_wr(A_UTX, 4'b0001, 32'h0000_00A5);
        for (int i = 0; i < 40; i++) begin
            total++;
            if (uart_txd !== frame[i/4]) begin
                bad++;
                $display("FAIL drop_bit cycle=%0d got=%b exp=%b", i, uart_txd, frame[i/4]);
            end
            if (i == 8) begin
                daddr = A_UTX; we = 4'b0001; din = 32'h0000_003C; dce = 1'b1;
            end
            if (i == 9) idle();
            tick();
        end
        high_ok = 1'b1;
        for (int i = 0; i < 44; i++) begin
            if (uart_txd !== 1'b1) high_ok = 1'b0;
            tick();
        end
        total++; if (high_ok !== 1'b1) begin bad++; $display("FAIL drop_line_high got=%b exp=1", high_ok); end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0]  frame;
        logic [31:0] q;
        frame = {1'b1, 8'hA5, 1'b0};
        bus_wr(32'h0000_0040, 4'hF, 32'h5A5A_1234);
        bus_wr(A_LED, 4'hF, 32'h0000_A5A5);
        bus_rd(32'h0000_0040, q);
        total++; if (q !== 32'h5A5A_1234) begin bad++; $display("FAIL rst_pre_ram got=%h exp=%h", q, 32'h5A5A_1234); end
        bus_wr(A_UTX, 4'b0001, 32'h0000_00A5);
        for (int i = 0; i < 17; i++) begin
            total++;
            if (uart_txd !== frame[i/4]) begin
                bad++;
                $display("FAIL rst_pre_bit cycle=%0d got=%b exp=%b", i, uart_txd, frame[i/4]);
            end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (uart_txd !== 1'b1) begin bad++; $display("FAIL rst_txd got=%b exp=1", uart_txd); end
        total++; if (led !== 16'h0) begin bad++; $display("FAIL rst_led got=%h exp=%h", led, 16'h0); end
        total++; if (dm !== 32'h0) begin bad++; $display("FAIL rst_dm got=%h exp=%h", dm, 32'h0); end
        // cleared at the reset edge, counted once by the read edge
        bus_rd(A_TIMER, q);
        total++; if (q !== 32'h1) begin bad++; $display("FAIL rst_timer got=%h exp=%h", q, 32'h1); end
        bus_rd(A_USTAT, q);
        total++; if (q !== 32'h0) begin bad++; $display("FAIL rst_status got=%h exp=%h", q, 32'h0); end
        total++; if (uart_txd !== 1'b1) begin bad++; $display("FAIL rst_txd_hold got=%b exp=1", uart_txd); end
        bus_rd(32'h0000_0040, q);
        total++; if (q !== 32'h5A5A_1234) begin bad++; $display("FAIL rst_ram_kept got=%h exp=%h", q, 32'h5A5A_1234); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle();
        test_reset();
        test_ram_bytes();
        test_back_to_back();
        test_led();
        test_timer();
        test_uart_frame();
        test_uart_busy_drop();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
